// File: rtl/streamer_csr_responder_if.sv
// CSR request/response channel between a host (master) and
// streamer_csr_responder (slave). Requests carry a 32-bit register index,
// write data and a write flag; read responses come back on the rsp channel.
interface streamer_csr_responder_if #(
   parameter int DataWidth = 32
);
   logic [31:0]          io_csr_req_bits_addr_i;
   logic [DataWidth-1:0] io_csr_req_bits_data_i;
   logic                 io_csr_req_bits_write_i;
   logic                 io_csr_req_valid_i;
   logic                 io_csr_req_ready_o;
   logic [DataWidth-1:0] io_csr_rsp_bits_data_o;
   logic                 io_csr_rsp_valid_o;
   logic                 io_csr_rsp_ready_i;

   modport master (
      output io_csr_req_bits_addr_i,
      output io_csr_req_bits_data_i,
      output io_csr_req_bits_write_i,
      output io_csr_req_valid_i,
      input  io_csr_req_ready_o,
      input  io_csr_rsp_bits_data_o,
      input  io_csr_rsp_valid_o,
      output io_csr_rsp_ready_i
   );

   modport slave (
      input  io_csr_req_bits_addr_i,
      input  io_csr_req_bits_data_i,
      input  io_csr_req_bits_write_i,
      input  io_csr_req_valid_i,
      output io_csr_req_ready_o,
      output io_csr_rsp_bits_data_o,
      output io_csr_rsp_valid_o,
      input  io_csr_rsp_ready_i
   );
endinterface

// File: rtl/streamer_csr_responder.sv
// CSR responder for a streamer accelerator.
//   - NumCfgRegs read/write configuration registers at addresses 0..NumCfgRegs-1,
//     exported flat on cfg_o.
//   - Address NumCfgRegs: start/status. Writing bit0=1 pulses start_o for one
//     cycle; reading returns busy_i in bit 0.
//   - Reads answer with latency 1 through a one-entry response buffer;
//     writes produce no response.
//   - Writes to the register/start space stall while the streamer is busy.
// Optional feature, enabled by defining SNAX_CSR_PERF_CNT_EN: a read-only
// busy-cycle counter at address NumCfgRegs+1 (cleared on start, saturating).
module streamer_csr_responder #(
   parameter int NumCfgRegs = 13,
   parameter int DataWidth  = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   streamer_csr_responder_if.slave          csr,
   output logic [NumCfgRegs*DataWidth-1:0]  cfg_o,
   output logic                             start_o,
   input  logic                             busy_i
);

   localparam logic [31:0] StatusAddr = 32'(NumCfgRegs);
`ifdef SNAX_CSR_PERF_CNT_EN
   localparam logic [31:0] PerfAddr   = 32'(NumCfgRegs + 1);
`endif

   logic [DataWidth-1:0] cfg_q [NumCfgRegs];
   logic                 rsp_valid_q;
   logic [DataWidth-1:0] rsp_data_q;
   logic                 start_q;
   logic [DataWidth-1:0] rd_data;
`ifdef SNAX_CSR_PERF_CNT_EN
   logic [DataWidth-1:0] perf_cnt_q;
`endif

   logic [31:0]          req_addr;
   logic                 req_is_write;
   logic                 rsp_blocked;
   logic                 write_stall;
   logic                 wr_fire;
   logic                 rd_fire;

   assign req_addr     = csr.io_csr_req_bits_addr_i;
   assign req_is_write = csr.io_csr_req_bits_write_i;

   // A pending response that is not being drained this cycle fills the
   // single buffer entry; there is no bypass path.
   assign rsp_blocked  = rsp_valid_q && !csr.io_csr_rsp_ready_i;
   // Config and start writes must not disturb a running streamer.
   assign write_stall  = req_is_write && (req_addr <= StatusAddr) && busy_i;

   assign csr.io_csr_req_ready_o = !rsp_blocked && !write_stall;
   assign wr_fire = csr.io_csr_req_valid_i && csr.io_csr_req_ready_o && req_is_write;
   assign rd_fire = csr.io_csr_req_valid_i && csr.io_csr_req_ready_o && !req_is_write;

   // Read data selection for the address being requested this cycle.
   always_comb begin
      // NOTE: rd_data gets a default before any branch so no latch is inferred.
      rd_data = '0;
      for (int k = 0; k < NumCfgRegs; k++) begin
         if (req_addr == 32'(k)) rd_data = cfg_q[k];
      end
      if (req_addr == StatusAddr) rd_data[0] = busy_i;
`ifdef SNAX_CSR_PERF_CNT_EN
      if (req_addr == PerfAddr) rd_data = perf_cnt_q;
`endif
   end

   // Configuration registers: change only on an accepted in-range write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the register file is built from flops, not a RAM macro, so it
         // is cleared by the async reset like any other state.
         for (int k = 0; k < NumCfgRegs; k++) cfg_q[k] <= '0;
      end else begin
         for (int k = 0; k < NumCfgRegs; k++) begin
            if (wr_fire && req_addr == 32'(k)) cfg_q[k] <= csr.io_csr_req_bits_data_i;
         end
      end
   end

   for (genvar k = 0; k < NumCfgRegs; k++) begin : g_cfg_out
      assign cfg_o[k*DataWidth +: DataWidth] = cfg_q[k];
   end

   // One-entry response buffer: load on read accept, drain on handshake.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: sequential state uses <= so every flop samples pre-edge values.
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else if (rd_fire) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= rd_data;
      end else if (csr.io_csr_rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign csr.io_csr_rsp_valid_o     = rsp_valid_q;
   assign csr.io_csr_rsp_bits_data_o = rsp_data_q;

   // Start pulse: one cycle after a write of bit0=1 to the status address.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) start_q <= 1'b0;
      else         start_q <= wr_fire && (req_addr == StatusAddr) &&
                              csr.io_csr_req_bits_data_i[0];
   end

   assign start_o = start_q;

`ifdef SNAX_CSR_PERF_CNT_EN
   // Busy-cycle counter: cleared by the launch pulse, saturates at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          perf_cnt_q <= '0;
      else if (start_q)                     perf_cnt_q <= '0;
      else if (busy_i && perf_cnt_q != '1)  perf_cnt_q <= perf_cnt_q + DataWidth'(1);
   end
`endif

endmodule
